// File: rtl/control_mem_access.sv
// control_mem_access: memory-stage sequencer for direct/indirect loads and stores.
// Optional MEM_PROT_EN suppresses stores at or above PROT_BASE and flags prot_err.
module control_mem_access #(
   parameter int          RD_LAT    = 1,
   parameter logic [15:0] PROT_BASE = 16'hFE00
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic        Mem_Control,
   input  logic        is_store,
   input  logic [15:0] M_Addr,
   input  logic [15:0] M_Data,
   input  logic [15:0] Data_dout,
   output logic [15:0] Data_addr,
   output logic [15:0] Data_din,
   output logic        Data_rd,
   output logic        Data_we,
   output logic [15:0] memory_dout,
   output logic        busy,
   output logic        done,
   output logic        prot_err
);
   localparam int CW = $clog2(RD_LAT + 1);
   typedef enum logic [2:0] {IDLE, IND_RD, DATA_RD, DATA_WR, DONE} state_t;
   state_t state, next;
   logic [CW-1:0] cnt;
   logic [15:0] a, d, ptr, last_addr, fa;
   logic ind, st, rd_last, prot;
   assign rd_last = cnt == CW'(RD_LAT - 1);
   assign fa = ind ? ptr : a;
`ifdef MEM_PROT_EN
   assign prot = st && fa >= PROT_BASE;
`else
   assign prot = 1'b0;
`endif
   assign busy = state != IDLE;
   assign done = state == DONE;
   assign prot_err = done && prot;
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= IDLE;
         cnt <= '0;
         a <= '0;
         d <= '0;
         ptr <= '0;
         ind <= 1'b0;
         st <= 1'b0;
         last_addr <= '0;
         memory_dout <= '0;
      end else begin
         state <= next;
         // cleared on every state change, saturates while waiting
         cnt <= (next != state) ? '0 : (cnt == CW'(RD_LAT) ? cnt : cnt + 1'b1);
         last_addr <= Data_addr;
         if (state == IDLE && start) begin
            a <= M_Addr;
            d <= M_Data;
            ind <= Mem_Control;
            st <= is_store;
         end
         if (state == IND_RD && rd_last) ptr <= Data_dout;
         if (state == DATA_RD && rd_last) memory_dout <= Data_dout;
      end
   end
   always_comb begin
      next = state;
      Data_addr = last_addr;
      Data_din = '0;
      Data_rd = 1'b1;
      Data_we = 1'b0;
      case (state)
         IDLE:    next = start ? (Mem_Control ? IND_RD : (is_store ? DATA_WR : DATA_RD)) : IDLE;
         IND_RD: begin
            Data_addr = a;
            next = rd_last ? (st ? DATA_WR : DATA_RD) : IND_RD;
         end
         DATA_RD: begin
            Data_addr = fa;
            next = rd_last ? DONE : DATA_RD;
         end
         DATA_WR: begin
            Data_addr = fa;
            Data_din = d;
            Data_rd = 1'b0;
            Data_we = !prot;
            next = DONE;
         end
         DONE:    next = IDLE;
         default: next = IDLE;
      endcase
   end
endmodule

// File: tb/tb_control_mem_access.sv
// tb_control_mem_access: directed bench for control_mem_access with RD_LAT=1
// and a combinational data-memory model.
module tb_control_mem_access;
   logic clk = 1'b0, rst = 1'b0, start = 1'b0, Mem_Control = 1'b0, is_store = 1'b0;
   logic [15:0] M_Addr = '0, M_Data = '0, Data_dout, Data_addr, Data_din, memory_dout;
   logic Data_rd, Data_we, busy, done, prot_err;
   logic [15:0] mem [0:65535];
   int n_checks = 0, n_fail = 0, we_cnt = 0;
   logic saw6000 = 1'b0;

   control_mem_access #(.RD_LAT(1), .PROT_BASE(16'hFE00)) dut (
      .clk(clk), .rst(rst), .start(start), .Mem_Control(Mem_Control), .is_store(is_store),
      .M_Addr(M_Addr), .M_Data(M_Data), .Data_dout(Data_dout), .Data_addr(Data_addr),
      .Data_din(Data_din), .Data_rd(Data_rd), .Data_we(Data_we), .memory_dout(memory_dout),
      .busy(busy), .done(done), .prot_err(prot_err));

   always #5 clk = ~clk;
   assign Data_dout = mem[Data_addr];
   always @(posedge clk) if (Data_we) mem[Data_addr] <= Data_din;
   always @(negedge clk) begin
      if (Data_we) we_cnt <= we_cnt + 1;
      if (Data_addr == 16'h6000) saw6000 <= 1'b1;
   end

   task automatic issue(input logic ind, input logic st, input logic [15:0] addr, input logic [15:0] data);
      @(negedge clk);
      Mem_Control = ind; is_store = st; M_Addr = addr; M_Data = data; start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
   endtask

   task automatic test_reset;
      #3;
      n_checks++; if (Data_addr !== 16'h0) begin n_fail++; $display("FAIL reset_addr got %h exp 0000", Data_addr); end
      n_checks++; if ({Data_rd, Data_we, busy, done, prot_err} !== 5'b10000) begin n_fail++; $display("FAIL reset_ctl got %b exp 10000", {Data_rd, Data_we, busy, done, prot_err}); end
      n_checks++; if (memory_dout !== 16'h0) begin n_fail++; $display("FAIL reset_mdout got %h exp 0000", memory_dout); end
      @(negedge clk) rst = 1'b1;
   endtask

   task automatic test_ld;
      mem[16'h3010] = 16'hABCD;
      issue(1'b0, 1'b0, 16'h3010, 16'h0);
      @(negedge clk);
      n_checks++; if ({Data_addr, Data_rd, busy, done} !== {16'h3010, 3'b110}) begin n_fail++; $display("FAIL ld_c1 got %h/%b%b%b exp 3010/110", Data_addr, Data_rd, busy, done); end
      @(negedge clk);
      n_checks++; if ({done, memory_dout} !== {1'b1, 16'hABCD}) begin n_fail++; $display("FAIL ld_c2 got %b/%h exp 1/abcd", done, memory_dout); end
      @(negedge clk);
      n_checks++; if ({busy, done, Data_rd, Data_addr} !== {3'b001, 16'h3010}) begin n_fail++; $display("FAIL ld_idle got %b%b%b/%h exp 001/3010", busy, done, Data_rd, Data_addr); end
   endtask

   task automatic test_ldi;
      mem[16'h3020] = 16'h4000; mem[16'h4000] = 16'h1234;
      issue(1'b1, 1'b0, 16'h3020, 16'h0);
      @(negedge clk);
      n_checks++; if (Data_addr !== 16'h3020) begin n_fail++; $display("FAIL ldi_c1 got %h exp 3020", Data_addr); end
      @(negedge clk);
      n_checks++; if ({Data_addr, done} !== {16'h4000, 1'b0}) begin n_fail++; $display("FAIL ldi_c2 got %h/%b exp 4000/0", Data_addr, done); end
      @(negedge clk);
      n_checks++; if ({done, memory_dout} !== {1'b1, 16'h1234}) begin n_fail++; $display("FAIL ldi_c3 got %b/%h exp 1/1234", done, memory_dout); end
   endtask

   task automatic test_sti;
      mem[16'h3030] = 16'h5000;
      issue(1'b1, 1'b1, 16'h3030, 16'hBEEF);
      @(negedge clk);
      n_checks++; if ({Data_addr, Data_we, Data_rd} !== {16'h3030, 2'b01}) begin n_fail++; $display("FAIL sti_c1 got %h/%b%b exp 3030/01", Data_addr, Data_we, Data_rd); end
      @(negedge clk);
      n_checks++; if ({Data_addr, Data_din, Data_we, Data_rd, done} !== {16'h5000, 16'hBEEF, 3'b100}) begin n_fail++; $display("FAIL sti_c2 got %h/%h/%b%b%b exp 5000/beef/100", Data_addr, Data_din, Data_we, Data_rd, done); end
      @(negedge clk);
      n_checks++; if ({done, Data_we, mem[16'h5000]} !== {2'b10, 16'hBEEF}) begin n_fail++; $display("FAIL sti_c3 got %b%b/%h exp 10/beef", done, Data_we, mem[16'h5000]); end
      n_checks++; if (memory_dout !== 16'h1234) begin n_fail++; $display("FAIL sti_mdout got %h exp 1234", memory_dout); end
   endtask

   task automatic test_boundary;
      issue(1'b0, 1'b1, 16'h0000, 16'h1111);
      @(negedge clk);
      n_checks++; if ({Data_addr, Data_we, Data_din} !== {16'h0000, 1'b1, 16'h1111}) begin n_fail++; $display("FAIL st0_c1 got %h/%b/%h exp 0000/1/1111", Data_addr, Data_we, Data_din); end
      @(negedge clk);
      n_checks++; if ({done, Data_we, mem[16'h0000]} !== {2'b10, 16'h1111}) begin n_fail++; $display("FAIL st0_c2 got %b%b/%h exp 10/1111", done, Data_we, mem[16'h0000]); end
      mem[16'h3040] = 16'hFFFF; mem[16'hFFFF] = 16'h7777;
      issue(1'b1, 1'b0, 16'h3040, 16'h0);
      @(negedge clk);
      @(negedge clk);
      n_checks++; if (Data_addr !== 16'hFFFF) begin n_fail++; $display("FAIL ldi_ffff_addr got %h exp ffff", Data_addr); end
      @(negedge clk);
      n_checks++; if ({done, memory_dout} !== {1'b1, 16'h7777}) begin n_fail++; $display("FAIL ldi_ffff_done got %b/%h exp 1/7777", done, memory_dout); end
   endtask

   task automatic test_ignore_start;
      issue(1'b1, 1'b0, 16'h3020, 16'h0);
      @(negedge clk);
      n_checks++; if (Data_addr !== 16'h3020) begin n_fail++; $display("FAIL ign_c1 got %h exp 3020", Data_addr); end
      Mem_Control = 1'b0; is_store = 1'b1; M_Addr = 16'h6000; M_Data = 16'hDEAD; start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      @(negedge clk);
      n_checks++; if ({Data_addr, Data_rd, Data_we} !== {16'h4000, 2'b10}) begin n_fail++; $display("FAIL ign_c2 got %h/%b%b exp 4000/10", Data_addr, Data_rd, Data_we); end
      @(negedge clk);
      n_checks++; if ({done, memory_dout} !== {1'b1, 16'h1234}) begin n_fail++; $display("FAIL ign_c3 got %b/%h exp 1/1234", done, memory_dout); end
      @(negedge clk);
      n_checks++; if ({busy, saw6000, mem[16'h6000]} !== {2'b00, 16'h0}) begin n_fail++; $display("FAIL ign_after got %b%b/%h exp 00/0000", busy, saw6000, mem[16'h6000]); end
   endtask

   task automatic test_reset_mid;
      int we0;
      we0 = we_cnt;
      issue(1'b1, 1'b1, 16'h3030, 16'hCAFE);
      @(negedge clk);
      rst = 1'b0;
      #1;
      n_checks++; if ({Data_addr, Data_rd, Data_we, busy, done} !== {16'h0, 4'b1000}) begin n_fail++; $display("FAIL rstmid got %h/%b%b%b%b exp 0000/1000", Data_addr, Data_rd, Data_we, busy, done); end
      @(negedge clk) rst = 1'b1;
      @(negedge clk);
      @(negedge clk);
      n_checks++; if ({we_cnt == we0, mem[16'h5000]} !== {1'b1, 16'hBEEF}) begin n_fail++; $display("FAIL rstmid_nowe got %0d/%h exp %0d/beef", we_cnt, mem[16'h5000], we0); end
      issue(1'b0, 1'b1, 16'h3100, 16'h2222);
      @(negedge clk);
      n_checks++; if ({Data_addr, Data_we} !== {16'h3100, 1'b1}) begin n_fail++; $display("FAIL rstmid_st got %h/%b exp 3100/1", Data_addr, Data_we); end
      @(negedge clk);
      n_checks++; if ({done, mem[16'h3100]} !== {1'b1, 16'h2222}) begin n_fail++; $display("FAIL rstmid_done got %b/%h exp 1/2222", done, mem[16'h3100]); end
   endtask

   task automatic test_prot;
      issue(1'b0, 1'b1, 16'hFE04, 16'h9999);
      @(negedge clk);
`ifdef MEM_PROT_EN
      n_checks++; if ({Data_we, Data_addr} !== {1'b0, 16'hFE04}) begin n_fail++; $display("FAIL prot_c1 got %b/%h exp 0/fe04", Data_we, Data_addr); end
      @(negedge clk);
      n_checks++; if ({done, prot_err, mem[16'hFE04]} !== {2'b11, 16'h0}) begin n_fail++; $display("FAIL prot_c2 got %b%b/%h exp 11/0000", done, prot_err, mem[16'hFE04]); end
`else
      n_checks++; if ({Data_we, Data_addr} !== {1'b1, 16'hFE04}) begin n_fail++; $display("FAIL noprot_c1 got %b/%h exp 1/fe04", Data_we, Data_addr); end
      @(negedge clk);
      n_checks++; if ({done, prot_err, mem[16'hFE04]} !== {2'b10, 16'h9999}) begin n_fail++; $display("FAIL noprot_c2 got %b%b/%h exp 10/9999", done, prot_err, mem[16'hFE04]); end
`endif
      issue(1'b0, 1'b1, 16'hFDFF, 16'h8888);
      @(negedge clk);
      n_checks++; if (Data_we !== 1'b1) begin n_fail++; $display("FAIL fdff_we got %b exp 1", Data_we); end
      @(negedge clk);
      n_checks++; if ({done, prot_err, mem[16'hFDFF]} !== {2'b10, 16'h8888}) begin n_fail++; $display("FAIL fdff_done got %b%b/%h exp 10/8888", done, prot_err, mem[16'hFDFF]); end
   endtask

   initial begin
      for (int i = 0; i < 65536; i++) mem[i] = 16'h0;
      test_reset;
      test_ld;
      test_ldi;
      test_sti;
      test_boundary;
      test_ignore_start;
      test_reset_mid;
      test_prot;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
